// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit: datapath width, step count and divider states.
package multdiv_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_STEPS = 32;

    localparam logic [DIV_WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

endpackage

// File: rtl/full_cla.sv
// 32-bit adder built from eight 4-bit carry-lookahead groups.
module full_cla (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [32:0] w_c;

    assign w_g    = a & b;
    assign w_p    = a ^ b;
    assign w_c[0] = c_in;

    for (genvar i = 0; i < 8; i++) begin : g_grp
        localparam int Base = 4 * i;

        assign w_c[Base+1] = w_g[Base] | (w_p[Base] & w_c[Base]);
        assign w_c[Base+2] = w_g[Base+1] | (w_p[Base+1] & w_g[Base])
                           | (w_p[Base+1] & w_p[Base] & w_c[Base]);
        assign w_c[Base+3] = w_g[Base+2] | (w_p[Base+2] & w_g[Base+1])
                           | (w_p[Base+2] & w_p[Base+1] & w_g[Base])
                           | (w_p[Base+2] & w_p[Base+1] & w_p[Base] & w_c[Base]);
        assign w_c[Base+4] = w_g[Base+3] | (w_p[Base+3] & w_g[Base+2])
                           | (w_p[Base+3] & w_p[Base+2] & w_g[Base+1])
                           | (w_p[Base+3] & w_p[Base+2] & w_p[Base+1] & w_g[Base])
                           | (w_p[Base+3] & w_p[Base+2] & w_p[Base+1] & w_p[Base] & w_c[Base]);
    end

    assign sum   = w_p ^ w_c[31:0];
    assign c_out = w_c[32];

endmodule

// File: rtl/div.sv
// Sequential signed 32-bit restoring divider: one shift/subtract step per clock, 32 steps.
module div import multdiv_pkg::*; (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_div,
    input  logic [DIV_WIDTH-1:0] data_operandA,
    input  logic [DIV_WIDTH-1:0] data_operandB,
    output logic [DIV_WIDTH-1:0] data_result,
    output logic                 data_exception,
    output logic                 data_resultRDY
);

    div_state_t r_state, w_state_d;

    logic [DIV_WIDTH-1:0] r_q;
    logic [DIV_WIDTH-1:0] r_d;
    logic [DIV_WIDTH-1:0] r_r;
    logic [5:0]           r_cnt;
    logic                 r_neg;
    logic                 r_dz;
    logic                 r_ovf;
    logic [DIV_WIDTH-1:0] r_result;
    logic                 r_exc;

    logic [DIV_WIDTH-1:0] w_a_abs;
    logic [DIV_WIDTH-1:0] w_b_abs;
    logic [DIV_WIDTH:0]   w_rs;
    logic [DIV_WIDTH-1:0] w_cla_a;
    logic [DIV_WIDTH-1:0] w_cla_b;
    logic [DIV_WIDTH-1:0] w_sum;
    logic                 w_cout;
    logic                 w_ge;
    logic                 w_done;
    logic [DIV_WIDTH-1:0] w_final;

    // Read as unsigned, the negation of INT_MIN is exactly 2^31, so no extra bit is needed.
    assign w_a_abs = data_operandA[DIV_WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign w_b_abs = data_operandB[DIV_WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

    // The stored remainder is always below the divisor, so only the shifted value needs 33 bits.
    assign w_rs   = {r_r, r_q[DIV_WIDTH-1]};
    assign w_done = (r_state == DONE);

    // Shared adder: trial subtract while running, quotient negate in DONE.
    assign w_cla_a = w_done ? '0 : w_rs[DIV_WIDTH-1:0];
    assign w_cla_b = w_done ? ~r_q : ~r_d;

    full_cla u_cla (
        .a     (w_cla_a),
        .b     (w_cla_b),
        .c_in  (1'b1),
        .sum   (w_sum),
        .c_out (w_cout)
    );

    assign w_ge = w_rs[DIV_WIDTH] | w_cout;

    always_comb begin
        w_final = r_neg ? w_sum : r_q;
        if (r_dz) begin
            w_final = '0;
        end else if (r_ovf) begin
            w_final = INT_MIN;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (ctrl_div) begin
            w_state_d = RUN;
        end else begin
            case (r_state)
                IDLE:    w_state_d = IDLE;
                RUN:     if (r_cnt == 6'(DIV_STEPS - 1)) w_state_d = DONE;
                DONE:    w_state_d = IDLE;
                default: w_state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_q      <= '0;
            r_d      <= '0;
            r_r      <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (ctrl_div) begin
                r_q   <= w_a_abs;
                r_d   <= w_b_abs;
                r_r   <= '0;
                r_cnt <= '0;
                r_neg <= data_operandA[DIV_WIDTH-1] ^ data_operandB[DIV_WIDTH-1];
                r_dz  <= (data_operandB == '0);
                r_ovf <= (data_operandA == INT_MIN) && (data_operandB == '1);
            end else if (r_state == RUN) begin
                r_r   <= w_ge ? w_sum : w_rs[DIV_WIDTH-1:0];
                r_q   <= {r_q[DIV_WIDTH-2:0], w_ge};
                r_cnt <= r_cnt + 6'd1;
            end
            // Capture the DONE values so they persist after the ready pulse.
            if (w_done) begin
                r_result <= w_final;
                r_exc    <= r_dz | r_ovf;
            end
        end
    end

    assign data_result    = w_done ? w_final : r_result;
    assign data_exception = w_done ? (r_dz | r_ovf) : r_exc;
    assign data_resultRDY = w_done;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed and random operands against a signed-division model.
module tb_div;

    logic        clk;
    logic        rst;
    logic        ctrl_div;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int errors;
    int checks;

    div dut (
        .clk            (clk),
        .rst            (rst),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {exception, quotient} straight from the arithmetic rules.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] q;
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        return {1'b0, q};
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ctrl_div      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clk);
        ctrl_div      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Watches 40 cycles after the start edge; reports first ready cycle and pulse count.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res,
                          output logic exc, output int lat, output int pulses);
        lat    = -1;
        pulses = 0;
        res    = 'x;
        exc    = 1'bx;
        start_op(a, b);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (data_resultRDY) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    res = data_result;
                    exc = data_exception;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        ctrl_div      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
            errors++;
            $display("FAIL reset_hold: got res=%h exc=%b rdy=%b, want 0 0 0",
                     data_result, data_exception, data_resultRDY);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
            errors++;
            $display("FAIL reset_idle: got res=%h exc=%b rdy=%b, want 0 0 0",
                     data_result, data_exception, data_resultRDY);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta[10] = '{32'd7, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'd123,
                                32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd5};
        logic [31:0] tb[10] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0,
                                32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd9, 32'h8000_0000};
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          pulses;
        logic [32:0] exp;
        for (int i = 0; i < 10; i++) begin
            exp = model(ta[i], tb[i]);
            run_op(ta[i], tb[i], res, exc, lat, pulses);
            checks++;
            if (lat != 32 || pulses != 1) begin
                errors++;
                $display("FAIL dir%0d_latency: got lat=%0d pulses=%0d, want 32 1", i, lat, pulses);
            end
            checks++;
            if (res !== exp[31:0] || exc !== exp[32]) begin
                errors++;
                $display("FAIL dir%0d_value %h/%h: got %h exc=%b, want %h exc=%b",
                         i, ta[i], tb[i], res, exc, exp[31:0], exp[32]);
            end
        end
        checks++;
        if (data_result !== exp[31:0] || data_exception !== exp[32] || data_resultRDY !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got %h exc=%b rdy=%b, want %h exc=%b rdy=0",
                     data_result, data_exception, data_resultRDY, exp[31:0], exp[32]);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          pulses;
        logic [32:0] exp;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom_range(1, 20);
                1: b = -32'($urandom_range(1, 20));
                2: b = 32'd0;
                3: a = 32'h8000_0000;
                default: ;
            endcase
            exp = model(a, b);
            run_op(a, b, res, exc, lat, pulses);
            checks++;
            if (lat != 32 || pulses != 1 || res !== exp[31:0] || exc !== exp[32]) begin
                errors++;
                $display("FAIL rand%0d %h/%h: got %h exc=%b lat=%0d pulses=%0d, want %h exc=%b lat=32",
                         i, a, b, res, exc, lat, pulses, exp[31:0], exp[32]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1 = 32'd1000;
        logic [31:0] b1 = 32'hFFFF_FFFD;
        logic [31:0] a2 = 32'hFFFF_FF00;
        logic [31:0] b2 = 32'd16;
        logic [32:0] exp1;
        logic [32:0] exp2;
        int          lat;
        int          pulses;
        exp1 = model(a1, b1);
        exp2 = model(a2, b2);
        start_op(a1, b1);
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if (data_resultRDY) lat = k;
        end
        checks++;
        if (lat != 32 || data_result !== exp1[31:0] || data_exception !== exp1[32]) begin
            errors++;
            $display("FAIL b2b_first: got %h exc=%b lat=%0d, want %h exc=%b lat=32",
                     data_result, data_exception, lat, exp1[31:0], exp1[32]);
        end
        ctrl_div      = 1'b1;
        data_operandA = a2;
        data_operandB = b2;
        #1;
        checks++;
        if (data_resultRDY !== 1'b1 || data_result !== exp1[31:0]) begin
            errors++;
            $display("FAIL b2b_done_hold: got rdy=%b res=%h, want rdy=1 res=%h",
                     data_resultRDY, data_result, exp1[31:0]);
        end
        @(negedge clk);
        ctrl_div = 1'b0;
        lat      = -1;
        pulses   = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (data_resultRDY) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    checks++;
                    if (data_result !== exp2[31:0] || data_exception !== exp2[32]) begin
                        errors++;
                        $display("FAIL b2b_second: got %h exc=%b, want %h exc=%b",
                                 data_result, data_exception, exp2[31:0], exp2[32]);
                    end
                end
            end
        end
        checks++;
        if (lat != 32 || pulses != 1) begin
            errors++;
            $display("FAIL b2b_latency: got lat=%0d pulses=%0d, want 32 1", lat, pulses);
        end
    endtask

    task automatic test_abort();
        int early;
        int lat;
        int pulses;
        logic [31:0] res;
        start_op(32'd100, 32'd7);
        early = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (data_resultRDY) early++;
        end
        ctrl_div      = 1'b1;
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        @(negedge clk);
        ctrl_div = 1'b0;
        lat      = -1;
        pulses   = 0;
        res      = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (data_resultRDY) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    res = data_result;
                end
            end
        end
        checks++;
        if (early != 0 || pulses != 1 || lat != 32) begin
            errors++;
            $display("FAIL abort_pulse: got early=%0d pulses=%0d lat=%0d, want 0 1 32",
                     early, pulses, lat);
        end
        checks++;
        if (res !== 32'd10) begin
            errors++;
            $display("FAIL abort_value: got %h, want %h", res, 32'd10);
        end
    endtask

    task automatic test_rst_mid();
        int pulses;
        start_op(32'd9, 32'd3);
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
            errors++;
            $display("FAIL rst_async: got res=%h exc=%b rdy=%b, want 0 0 0",
                     data_result, data_exception, data_resultRDY);
        end
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (data_resultRDY) pulses++;
        end
        checks++;
        if (pulses != 0 || data_result !== 32'd0) begin
            errors++;
            $display("FAIL rst_no_pulse: got pulses=%0d res=%h, want 0 0", pulses, data_result);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_abort();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
